// File: rtl/multdiv_pkg.sv
// -----------------------------------------------------------------------------
// multdiv_pkg
//   Shared definitions for the multdiv sequencer: state and operation
//   encodings, default datapath iteration counts, the most-negative operand
//   value used by the signed-divide overflow check, and a helper that sizes the
//   iteration counter.
// -----------------------------------------------------------------------------
package multdiv_pkg;

  localparam int WIDTH_DEF       = 32;
  localparam int DIV_CYCLES_DEF  = 32;
  localparam int MULT_CYCLES_DEF = 32;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_LOAD    = 3'd1;
  localparam state_t ST_RUN     = 3'd2;
  localparam state_t ST_CAPTURE = 3'd3;
  localparam state_t ST_DONE    = 3'd4;

  typedef logic op_t;
  localparam op_t OP_MUL = 1'b0;
  localparam op_t OP_DIV = 1'b1;

  localparam logic [WIDTH_DEF-1:0] INT_MIN = 32'h8000_0000;

  // Bits needed to count 0 .. max(a,b)-1; never narrower than one bit.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/multdiv_if.sv
// -----------------------------------------------------------------------------
// multdiv_if
//   Bundles every non-clock signal of the multdiv sequencer.
//   master : processor + datapath side (drives commands, operands, mult_prod,
//            div_quot; observes result, flags, start pulses, dp_A/dp_B)
//   slave  : the sequencer itself (multdiv_ctrl)
// -----------------------------------------------------------------------------
interface multdiv_if
  import multdiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) ();

  // Processor command side
  logic               ctrl_MULT;
  logic               ctrl_DIV;
  logic [WIDTH-1:0]   data_operandA;
  logic [WIDTH-1:0]   data_operandB;
  logic [WIDTH-1:0]   data_result;
  logic               data_exception;
  logic               data_resultRDY;
  logic               busy;

  // Datapath side
  logic               mult_start;
  logic               div_start;
  logic [WIDTH-1:0]   dp_A;
  logic [WIDTH-1:0]   dp_B;
  logic [2*WIDTH-1:0] mult_prod;
  logic [WIDTH-1:0]   div_quot;

  modport master (
    output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB, mult_prod, div_quot,
    input  data_result, data_exception, data_resultRDY, busy,
           mult_start, div_start, dp_A, dp_B
  );

  modport slave (
    input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB, mult_prod, div_quot,
    output data_result, data_exception, data_resultRDY, busy,
           mult_start, div_start, dp_A, dp_B
  );

endinterface

// File: rtl/multdiv_cycle_counter.sv
// -----------------------------------------------------------------------------
// multdiv_cycle_counter
//   Iteration counter with synchronous clear and count enable. o_tc compares
//   the current count against a limit supplied at run time, so one counter
//   serves both the multiply and divide iteration lengths.
//   Ports:
//     clock    in   rising-edge clock
//     reset    in   asynchronous active-low reset
//     i_clr    in   synchronous clear (wins over i_en)
//     i_en     in   increment enable
//     i_limit  in   terminal count value
//     o_count  out  current count
//     o_tc     out  count equals i_limit
// -----------------------------------------------------------------------------
module multdiv_cycle_counter #(
  parameter int CNT_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_limit,
  output logic [CNT_W-1:0] o_count,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_count;

  // NOTE: clocked state uses non-blocking (<=) so every register samples the
  // pre-edge value of every other register, independent of block ordering.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_tc    = (r_count == i_limit);

endmodule

// File: rtl/multdiv_ctrl.sv
// -----------------------------------------------------------------------------
// multdiv_ctrl
//   Sequencer between the processor's multdiv interface and the iterative
//   multiplier / divider datapaths. A one-cycle ctrl_MULT / ctrl_DIV latches
//   the operands, pulses the matching datapath start, waits the datapath's
//   iteration count, captures the result with its exception flag and returns
//   a one-cycle data_resultRDY. Divide-by-zero and INT_MIN / -1 are answered
//   directly without running the divider. A new command always restarts the
//   sequence, silently dropping any operation still in flight.
//   Ports:
//     clock  in   rising-edge clock
//     reset  in   asynchronous active-low reset
//     bus    slave modport of multdiv_if (commands, operands, result, flags,
//            start pulses, datapath operands and datapath results)
// -----------------------------------------------------------------------------
module multdiv_ctrl
  import multdiv_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int MULT_CYCLES = MULT_CYCLES_DEF
) (
  input  logic     clock,
  input  logic     reset,
  multdiv_if.slave bus
);

  localparam int CNT_W = cnt_width(DIV_CYCLES, MULT_CYCLES);
  // Most-negative value at this WIDTH, taken from the package's sign bit.
  localparam logic [WIDTH-1:0] L_INT_MIN   = {INT_MIN[WIDTH_DEF-1], {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] L_DIV_LAST  = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_MULT_LAST = CNT_W'(MULT_CYCLES - 1);

  state_t           r_state;
  state_t           w_next;
  op_t              r_op;
  logic [WIDTH-1:0] r_dp_a;
  logic [WIDTH-1:0] r_dp_b;
  logic [WIDTH-1:0] r_result;
  logic             r_exception;

  logic             w_cmd;
  op_t              w_cmd_op;
  logic             w_fast;
  logic [WIDTH-1:0] w_fast_result;
  logic             w_mul_ovf;
  logic [CNT_W-1:0] w_limit;
  logic [CNT_W-1:0] w_count;
  logic             w_tc;
  logic             w_cnt_clr;
  logic             w_cnt_en;
  logic             w_busy;
  logic             w_rdy;
  logic             w_mult_start;
  logic             w_div_start;

  // Multiply wins when both commands arrive together.
  assign w_cmd    = bus.ctrl_MULT | bus.ctrl_DIV;
  assign w_cmd_op = bus.ctrl_MULT ? OP_MUL : OP_DIV;

  // Divide cases with a known answer, evaluated on the latched operands.
  assign w_fast        = (r_op == OP_DIV) &&
                         ((r_dp_b == '0) || ((r_dp_a == L_INT_MIN) && (r_dp_b == '1)));
  assign w_fast_result = (r_dp_b == '0) ? '0 : L_INT_MIN;

  // The low half is a valid signed result only if the high half is its sign
  // extension.
  assign w_mul_ovf = (bus.mult_prod[2*WIDTH-1:WIDTH] != {WIDTH{bus.mult_prod[WIDTH-1]}});

  assign w_limit   = (r_op == OP_MUL) ? L_MULT_LAST : L_DIV_LAST;
  assign w_cnt_clr = (r_state == ST_LOAD);
  // Holding at the terminal count keeps the counter from wrapping on RUN exit.
  assign w_cnt_en  = (r_state == ST_RUN) && !w_tc;

  multdiv_cycle_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clock   (clock),
    .reset   (reset),
    .i_clr   (w_cnt_clr),
    .i_en    (w_cnt_en),
    .i_limit (w_limit),
    .o_count (w_count),
    .o_tc    (w_tc)
  );

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: a command from any state restarts at LOAD.
  // NOTE: w_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    if (w_cmd) begin
      w_next = ST_LOAD;
    end else begin
      case (r_state)
        ST_IDLE:    w_next = ST_IDLE;
        ST_LOAD:    w_next = w_fast ? ST_DONE : ST_RUN;
        ST_RUN:     w_next = w_tc ? ST_CAPTURE : ST_RUN;
        ST_CAPTURE: w_next = ST_DONE;
        ST_DONE:    w_next = ST_IDLE;
        default:    w_next = ST_IDLE;
      endcase
    end
  end

  // Operand and operation latch, loaded only in the command cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_op   <= OP_MUL;
      r_dp_a <= '0;
      r_dp_b <= '0;
    end else if (w_cmd) begin
      r_op   <= w_cmd_op;
      r_dp_a <= bus.data_operandA;
      r_dp_b <= bus.data_operandB;
    end
  end

  // Result and exception hold until the next completion. A command arriving
  // in the same cycle aborts the operation, so nothing is written then.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_result    <= '0;
      r_exception <= 1'b0;
    end else if (!w_cmd) begin
      if (r_state == ST_CAPTURE) begin
        if (r_op == OP_DIV) begin
          r_result    <= bus.div_quot;
          r_exception <= 1'b0;
        end else begin
          r_result    <= bus.mult_prod[WIDTH-1:0];
          r_exception <= w_mul_ovf;
        end
      end else if ((r_state == ST_LOAD) && w_fast) begin
        r_result    <= w_fast_result;
        r_exception <= 1'b1;
      end
    end
  end

  // Outputs decoded from the state register only, so they are glitch-free and
  // cleared directly by reset.
  always_comb begin
    w_busy       = 1'b0;
    w_rdy        = 1'b0;
    w_mult_start = 1'b0;
    w_div_start  = 1'b0;
    case (r_state)
      ST_LOAD: begin
        w_busy       = 1'b1;
        w_mult_start = (r_op == OP_MUL);
        w_div_start  = (r_op == OP_DIV) && !w_fast;
      end
      ST_RUN, ST_CAPTURE: w_busy = 1'b1;
      ST_DONE:            w_rdy  = 1'b1;
      default: ;
    endcase
  end

  assign bus.data_result    = r_result;
  assign bus.data_exception = r_exception;
  assign bus.data_resultRDY = w_rdy;
  assign bus.busy           = w_busy;
  assign bus.mult_start     = w_mult_start;
  assign bus.div_start      = w_div_start;
  assign bus.dp_A           = r_dp_a;
  assign bus.dp_B           = r_dp_b;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multdiv_ctrl
//   Directed and randomized bench for multdiv_ctrl. Stub datapaths present a
//   valid product / quotient only once their iteration count has elapsed after
//   the start pulse (inverted garbage before that). Expected results, flags and
//   latencies come from an arithmetic reference model of the operation.
//   Sample point k is the falling edge just before rising edge E+k, where E is
//   the edge that samples the command.
// -----------------------------------------------------------------------------
module tb_multdiv_ctrl;
  import multdiv_pkg::*;

  localparam int W    = 32;
  localparam int NDIV = 32;
  localparam int NMUL = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;

  multdiv_if #(.WIDTH(W)) bus ();

  multdiv_ctrl #(
    .WIDTH       (W),
    .DIV_CYCLES  (NDIV),
    .MULT_CYCLES (NMUL)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // ---------------- stub datapaths ----------------
  logic [63:0] m_val = '0;
  logic [31:0] d_val = '0;
  int          m_cnt = 0;
  int          d_cnt = 0;

  always @(posedge clock) begin
    if (bus.mult_start) begin
      m_val <= {{32{bus.dp_A[31]}}, bus.dp_A} * {{32{bus.dp_B[31]}}, bus.dp_B};
      m_cnt <= 0;
    end else if (m_cnt < NMUL) begin
      m_cnt <= m_cnt + 1;
    end
    if (bus.div_start) begin
      if (bus.dp_B == '0)       d_val <= 32'hDEAD_BEEF;
      else if (bus.dp_B == '1)  d_val <= -bus.dp_A;
      else                      d_val <= 32'($signed(bus.dp_A) / $signed(bus.dp_B));
      d_cnt <= 0;
    end else if (d_cnt < NDIV) begin
      d_cnt <= d_cnt + 1;
    end
  end

  assign bus.mult_prod = (m_cnt == NMUL) ? m_val : ~m_val;
  assign bus.div_quot  = (d_cnt == NDIV) ? d_val : ~d_val;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model(input bit m, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output bit e, output int lat,
                       output bit fast);
    logic signed [63:0] sa, sb, p;
    logic signed [31:0] qa, qb;
    fast = 1'b0;
    if (m) begin
      sa  = $signed(a);
      sb  = $signed(b);
      p   = sa * sb;
      r   = p[31:0];
      e   = (p > 64'sd2147483647) || (p < -64'sd2147483648);
      lat = NMUL + 3;
    end else if (b == 32'd0) begin
      r = 32'd0; e = 1'b1; lat = 2; fast = 1'b1;
    end else if (a == INT_MIN && b == 32'hFFFF_FFFF) begin
      r = INT_MIN; e = 1'b1; lat = 2; fast = 1'b1;
    end else begin
      qa  = a;
      qb  = b;
      r   = qa / qb;
      e   = 1'b0;
      lat = NDIV + 3;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  int rdy_k, rdy_n, ms_k, ms_n, ds_k, ds_n;
  bit busy_k1;

  // Called at a falling edge; returns at sample point 1 of the new command.
  task automatic issue(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
    bus.ctrl_MULT     = m;
    bus.ctrl_DIV      = d;
    bus.data_operandA = a;
    bus.data_operandB = b;
    @(negedge clock);
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = $urandom;
    bus.data_operandB = $urandom;
  endtask

  // Records sample points 1..n starting at the current falling edge.
  task automatic watch(input int n);
    rdy_k = -1; rdy_n = 0; ms_k = -1; ms_n = 0; ds_k = -1; ds_n = 0;
    busy_k1 = 1'b0;
    for (int k = 1; k <= n; k++) begin
      if (k > 1) @(negedge clock);
      if (k == 1) busy_k1 = bus.busy;
      if (bus.data_resultRDY) begin rdy_n++; if (rdy_k < 0) rdy_k = k; end
      if (bus.mult_start)     begin ms_n++;  if (ms_k < 0)  ms_k  = k; end
      if (bus.div_start)      begin ds_n++;  if (ds_k < 0)  ds_k  = k; end
    end
  endtask

  task automatic check_op(input string tag, input bit m, input logic [31:0] exp_r,
                          input bit exp_e, input int lat, input bit fast);
    check({tag, "_rdy_lat"}, 64'(rdy_k), 64'(lat));
    check({tag, "_rdy_cnt"}, 64'(rdy_n), 64'd1);
    if (m) begin
      check({tag, "_mstart_at"}, 64'(ms_k), 64'd1);
      check({tag, "_mstart_cnt"}, 64'(ms_n), 64'd1);
      check({tag, "_dstart_cnt"}, 64'(ds_n), 64'd0);
    end else if (fast) begin
      check({tag, "_mstart_cnt"}, 64'(ms_n), 64'd0);
      check({tag, "_dstart_cnt"}, 64'(ds_n), 64'd0);
    end else begin
      check({tag, "_dstart_at"}, 64'(ds_k), 64'd1);
      check({tag, "_dstart_cnt"}, 64'(ds_n), 64'd1);
      check({tag, "_mstart_cnt"}, 64'(ms_n), 64'd0);
    end
    check({tag, "_result"}, 64'(bus.data_result), 64'(exp_r));
    check({tag, "_exc"}, 64'(bus.data_exception), 64'(exp_e));
  endtask

  task automatic do_op(input string tag, input bit m, input bit d,
                       input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    bit          e, fast;
    int          lat;
    model(m, a, b, r, e, lat, fast);
    issue(m, d, a, b);
    watch(lat + 6);
    check({tag, "_busy1"}, 64'(busy_k1), 64'd1);
    check_op(tag, m, r, e, lat, fast);
    check({tag, "_busy_end"}, 64'(bus.busy), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  64'(bus.busy), 64'd0);
    check({tag, "_rdy"},   64'(bus.data_resultRDY), 64'd0);
    check({tag, "_ms"},    64'(bus.mult_start), 64'd0);
    check({tag, "_ds"},    64'(bus.div_start), 64'd0);
    check({tag, "_dpa"},   64'(bus.dp_A), 64'd0);
    check({tag, "_dpb"},   64'(bus.dp_B), 64'd0);
    check({tag, "_res"},   64'(bus.data_result), 64'd0);
    check({tag, "_exc"},   64'(bus.data_exception), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, b, r;
    bit          e, fast;
    int          lat, kind;

    bus.ctrl_MULT = 1'b0;  bus.ctrl_DIV = 1'b0;
    bus.data_operandA = '0; bus.data_operandB = '0;

    // Reset state
    #1 reset = 1'b0;
    #1 check_all_zero("reset");
    @(negedge clock); @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // Normal divide
    do_op("div_100_m7", 1'b0, 1'b1, 32'd100, 32'hFFFF_FFF9);
    // Divide fast paths
    do_op("div_by_zero", 1'b0, 1'b1, 32'd5, 32'd0);
    do_op("div_intmin", 1'b0, 1'b1, INT_MIN, 32'hFFFF_FFFF);
    // Multiply overflow and signed in-range product
    do_op("mul_ovf", 1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);
    do_op("mul_m3x4", 1'b1, 1'b0, 32'hFFFF_FFFD, 32'd4);

    // Asynchronous reset in the middle of a divide
    issue(1'b0, 1'b1, 32'd100, 32'd3);
    watch(10);
    #2 reset = 1'b0;
    #1 check_all_zero("midrun_reset");
    @(negedge clock);
    reset = 1'b1;
    watch(NDIV + 8);
    check("post_reset_rdy", 64'(rdy_n), 64'd0);
    check("post_reset_ms", 64'(ms_n), 64'd0);
    check("post_reset_ds", 64'(ds_n), 64'd0);
    check("post_reset_busy", 64'(bus.busy), 64'd0);

    // Abort a divide with a multiply sampled at E+10
    issue(1'b0, 1'b1, 32'd1000, 32'd7);
    watch(9);
    check("abort_div_start", 64'(ds_k), 64'd1);
    check("abort_no_rdy_a", 64'(rdy_n), 64'd0);
    @(negedge clock);
    a = 32'd12345; b = 32'hFFFF_E57B;
    model(1'b1, a, b, r, e, lat, fast);
    issue(1'b1, 1'b0, a, b);
    watch(lat + 6);
    check_op("abort_mul", 1'b1, r, e, lat, fast);

    // Both commands high: multiply wins
    do_op("both_cmds", 1'b1, 1'b1, 32'd77, 32'hFFFF_FF00);

    // Command during DONE: finished op still reports, new op runs normally
    issue(1'b0, 1'b1, 32'd9, 32'd0);
    @(negedge clock);
    check("done_cmd_rdy", 64'(bus.data_resultRDY), 64'd1);
    check("done_cmd_res", 64'(bus.data_result), 64'd0);
    check("done_cmd_exc", 64'(bus.data_exception), 64'd1);
    a = 32'd300; b = 32'd41;
    model(1'b1, a, b, r, e, lat, fast);
    issue(1'b1, 1'b0, a, b);
    watch(lat + 6);
    check_op("done_cmd_mul", 1'b1, r, e, lat, fast);

    // Randomized operations
    for (int i = 0; i < 16; i++) begin
      kind = $urandom_range(0, 5);
      a = $urandom;
      b = $urandom;
      case (kind)
        0: do_op("rnd_mul", 1'b1, 1'b0, a, b);
        1: do_op("rnd_mul_small", 1'b1, 1'b0, {{16{a[15]}}, a[15:0]}, {{16{b[15]}}, b[15:0]});
        2: do_op("rnd_div", 1'b0, 1'b1, a, b);
        3: do_op("rnd_div_smallb", 1'b0, 1'b1, a, {{28{b[3]}}, b[3:0]});
        4: if (b[0]) do_op("rnd_div_ovf", 1'b0, 1'b1, INT_MIN, 32'hFFFF_FFFF);
           else      do_op("rnd_div_zero", 1'b0, 1'b1, a, 32'd0);
        default: do_op("rnd_both", 1'b1, 1'b1, a, b);
      endcase
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multdiv_ctrl.md
Name: multdiv_ctrl

Overview:
Sequencer between the processor's multdiv interface and the iterative multiplier and divider datapaths. It latches operands on a one-cycle ctrl_MULT/ctrl_DIV command and pulses the matching datapath start. It counts iterations, captures the result, and flags overflow and divide-by-zero itself. It raises a one-cycle data_resultRDY that the processor's stall logic waits on.

Parameters:
WIDTH, 32, operand/result width
DIV_CYCLES, 32, divider iterations after start (one quotient bit per cycle)
MULT_CYCLES, 32, multiplier iterations after start

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
ctrl_MULT  in  1  one-cycle multiply command
ctrl_DIV  in  1  one-cycle divide command
data_operandA  in  WIDTH  operand A, valid in the command cycle only
data_operandB  in  WIDTH  operand B, valid in the command cycle only
data_result  out  WIDTH  registered result
data_exception  out  1  registered overflow / divide-by-zero flag
data_resultRDY  out  1  one-cycle result-valid pulse
busy  out  1  operation in flight
mult_start  out  1  one-cycle load pulse to multiplier
div_start  out  1  one-cycle load pulse to divider
dp_A  out  WIDTH  registered operand A to both datapaths
dp_B  out  WIDTH  registered operand B to both datapaths
mult_prod  in  2*WIDTH  multiplier 64-bit product
div_quot  in  WIDTH  divider signed quotient

Behaviour:
- Reset (reset low, asynchronous): state IDLE, counter 0, dp_A/dp_B 0, data_result 0, data_exception 0, data_resultRDY 0, busy 0, mult_start 0, div_start 0.
- States are IDLE, LOAD, RUN, CAPTURE, DONE. Operation type (MUL/DIV) is held in a register op.
- Any state, command sampled (edge E):
  - Latch dp_A/dp_B and op; go to LOAD; busy=1.
  - ctrl_MULT and ctrl_DIV both high: MUL wins.
  - A command while busy aborts the in-flight operation and restarts. No RDY is issued for the aborted operation.
- DIV fast paths, checked on the latched operands in LOAD:
  - B==0: result 0, exception 1.
  - A==0x80000000 and B==0xFFFFFFFF: result 0x80000000, exception 1.
  - Either fast path skips RUN, does not pulse div_start, and goes to DONE. RDY is high at E+2.
- LOAD (normal path): assert the op's start for exactly this one cycle; counter cleared; go to RUN.
- RUN: counter increments each cycle. When counter == N-1 (N = DIV_CYCLES or MULT_CYCLES), go to CAPTURE.
- CAPTURE:
  - DIV: data_result = div_quot, exception 0.
  - MUL: data_result = mult_prod[31:0]. exception = 1 iff mult_prod[63:32] is not all copies of mult_prod[31].
  - Go to DONE.
- DONE: data_resultRDY=1 for one cycle; busy=0; go to IDLE.
- Normal latency: RDY high at E+N+3 (1 LOAD, N RUN, 1 CAPTURE, 1 DONE).
- data_result and data_exception hold their values until the next CAPTURE or fast-path DONE. They are not cleared by a new command.
- Start pulses are never asserted in the same cycle as each other, and never outside LOAD.
- A command in the DONE cycle: RDY still pulses for the finished operation; the new operation proceeds normally.
- Counter width is clog2(max(DIV_CYCLES, MULT_CYCLES)). The counter never wraps, because RUN always exits at N-1.

Decomposition:
- Shared package multdiv_pkg holds:
  - state encoding localparams (IDLE, LOAD, RUN, CAPTURE, DONE);
  - op encoding OP_MUL=0, OP_DIV=1;
  - default cycle counts;
  - the constant INT_MIN = 0x80000000.
- One sub-module, multdiv_cycle_counter: synchronous clear, enable, terminal-count compare against a runtime limit, async active-low reset.

Test Plan:
1. Reset low mid-RUN of a divide -> all outputs 0 at once; after release, no RDY and no start until a new command.
2. ctrl_DIV, A=100, B=-7, stub quotient -14 after DIV_CYCLES -> div_start at E+1 only; RDY at E+35; result 0xFFFFFFF2; exception 0.
3. ctrl_DIV, A=5, B=0 -> div_start never asserted; RDY at E+2; result 0; exception 1. Then A=0x80000000, B=-1 -> result 0x80000000, exception 1.
4. ctrl_MULT, A=0x10000, B=0x10000, stub product 0x1_00000000 -> RDY at E+35; result 0; exception 1. Then A=-3, B=4 (product 0xFFFFFFFF_FFFFFFF4) -> result 0xFFFFFFF4, exception 0.
5. ctrl_DIV, then ctrl_MULT at E+10 -> no RDY for the divide; mult_start at E+11; single RDY at E+45 carrying the multiply result.
6. ctrl_MULT and ctrl_DIV high together -> treated as multiply: mult_start pulses, div_start stays 0.
